// File: rtl/nettlp_eth_tx_sched.sv
// Per-packet round-robin scheduler for two NetTLP TLP sources onto a 64-bit Ethernet TX stream.
// Each frame is a 48-byte Eth/IPv4/UDP/NetTLP header followed by the granted source's payload.
module nettlp_eth_tx_sched #(
  parameter logic [47:0] SRC_MAC = 48'h00_11_22_33_44_55,
  parameter logic [47:0] DST_MAC = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP  = 32'hC0A8_0A01,
  parameter logic [31:0] DST_IP  = 32'hC0A8_0A03,
  parameter logic [7:0]  IP_TTL  = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tstamp_i,
  input  logic        cpl_req,
  input  logic [10:0] cpl_len,
  output logic        cpl_ack,
  input  logic [63:0] cpl_tdata,
  input  logic [7:0]  cpl_tkeep,
  input  logic        cpl_tlast,
  input  logic        cpl_tvalid,
  output logic        cpl_tready,
  input  logic        mr_req,
  input  logic [10:0] mr_len,
  output logic        mr_ack,
  input  logic [63:0] mr_tdata,
  input  logic [7:0]  mr_tkeep,
  input  logic        mr_tlast,
  input  logic        mr_tvalid,
  output logic        mr_tready,
  output logic [63:0] eth_tdata,
  output logic [7:0]  eth_tkeep,
  output logic        eth_tlast,
  output logic        eth_tvalid,
  output logic        eth_tuser,
  input  logic        eth_tready,
  output logic [1:0]  dbg_state
);
  // Handshake: a beat moves on a rising clk edge where tvalid && tready; a valid beat
  // and its data stay unchanged until accepted. req is held by a source until its ack pulse.
  typedef enum logic [1:0] {IDLE, LOAD, HDR, PAYLOAD} state_t;

  state_t      state;
  logic        sel_mr;
  logic        prio_mr;  // 1: MR wins the next tie (set to the source not granted last)
  logic [10:0] len_r;
  logic [31:0] tstamp_r;
  logic [9:0]  seq_r, cpl_seq, mr_seq;
  logic [15:0] tot_len, udp_len, csum;
  logic [2:0]  beat;

  logic        grant_mr;
  logic [15:0] tot_len_nxt, port;
  logic [19:0] sum0;
  logic [16:0] fold1, fold2;
  logic [63:0] hdr_be;

  assign grant_mr  = mr_req & (~cpl_req | prio_mr);
  assign cpl_ack   = (state == IDLE) & cpl_req & ~grant_mr;
  assign mr_ack    = (state == IDLE) & grant_mr;
  assign dbg_state = state;
  assign eth_tuser = 1'b0;
  assign port      = sel_mr ? 16'h4000 : 16'h3000;

  always_comb begin
    tot_len_nxt = {5'd0, len_r} + 16'd34;
    sum0 = 20'h4500 + {4'h0, tot_len_nxt} + 20'h4000 + {4'h0, IP_TTL, 8'h11}
         + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
         + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
    fold1 = {1'b0, sum0[15:0]} + {13'd0, sum0[19:16]};
    fold2 = {1'b0, fold1[15:0]} + {16'd0, fold1[16]};
  end

  // Header words are assembled with the first wire byte in [63:56].
  always_comb begin
    case (beat)
      3'd0:    hdr_be = {DST_MAC, SRC_MAC[47:32]};
      3'd1:    hdr_be = {SRC_MAC[31:0], 16'h0800, 8'h45, 8'h00};
      3'd2:    hdr_be = {tot_len, 16'h0000, 16'h4000, IP_TTL, 8'h11};
      3'd3:    hdr_be = {csum, SRC_IP, DST_IP[31:16]};
      3'd4:    hdr_be = {DST_IP[15:0], port, port, udp_len};
      default: hdr_be = {16'h0000, 6'b0, seq_r, tstamp_r};
    endcase
  end

  always_comb begin
    eth_tdata  = '0;
    eth_tkeep  = '0;
    eth_tlast  = 1'b0;
    eth_tvalid = 1'b0;
    cpl_tready = 1'b0;
    mr_tready  = 1'b0;
    if (state == HDR) begin
      eth_tvalid = 1'b1;
      eth_tkeep  = 8'hFF;
      for (int i = 0; i < 8; i++) eth_tdata[8*i +: 8] = hdr_be[63-8*i -: 8];
    end else if (state == PAYLOAD) begin
      if (sel_mr) begin
        eth_tdata  = mr_tdata;
        eth_tkeep  = mr_tkeep;
        eth_tlast  = mr_tlast;
        eth_tvalid = mr_tvalid;
        mr_tready  = eth_tready;
      end else begin
        eth_tdata  = cpl_tdata;
        eth_tkeep  = cpl_tkeep;
        eth_tlast  = cpl_tlast;
        eth_tvalid = cpl_tvalid;
        cpl_tready = eth_tready;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_mr   <= 1'b0;
      prio_mr  <= 1'b0;
      len_r    <= '0;
      tstamp_r <= '0;
      seq_r    <= '0;
      cpl_seq  <= '0;
      mr_seq   <= '0;
      tot_len  <= '0;
      udp_len  <= '0;
      csum     <= '0;
      beat     <= '0;
    end else begin
      case (state)
        IDLE: if (cpl_req | mr_req) begin
          sel_mr   <= grant_mr;
          len_r    <= grant_mr ? mr_len : cpl_len;
          seq_r    <= grant_mr ? mr_seq : cpl_seq;
          tstamp_r <= tstamp_i;
          state    <= LOAD;
        end
        LOAD: begin
          tot_len <= tot_len_nxt;
          udp_len <= {5'd0, len_r} + 16'd14;
          csum    <= ~fold2[15:0];
          beat    <= '0;
          state   <= HDR;
        end
        HDR: if (eth_tready) begin
          if (beat == 3'd5) begin
            state <= PAYLOAD;
            if (sel_mr) mr_seq <= mr_seq + 10'd1;
            else        cpl_seq <= cpl_seq + 10'd1;
          end else begin
            beat <= beat + 3'd1;
          end
        end
        default: if (eth_tvalid & eth_tready & eth_tlast) begin
          state   <= IDLE;
          prio_mr <= ~sel_mr;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nettlp_eth_tx_sched.sv
// Bench for nettlp_eth_tx_sched: source drivers, a frame-level model feeding an expected-beat
// queue, a vector table for header fields, and sequences for arbitration, stalls, wrap and reset.
module tb_nettlp_eth_tx_sched;
  localparam logic [47:0] T_SRC_MAC = 48'h00_11_22_33_44_55;
  localparam logic [47:0] T_DST_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] T_SRC_IP  = 32'hC0A8_0A01;
  localparam logic [31:0] T_DST_IP  = 32'hC0A8_0A03;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] tstamp_i = '0;
  logic cpl_req = 0, cpl_ack, cpl_tlast = 0, cpl_tvalid = 0, cpl_tready;
  logic [10:0] cpl_len = '0;
  logic [63:0] cpl_tdata = '0;
  logic [7:0]  cpl_tkeep = '0;
  logic mr_req = 0, mr_ack, mr_tlast = 0, mr_tvalid = 0, mr_tready;
  logic [10:0] mr_len = '0;
  logic [63:0] mr_tdata = '0;
  logic [7:0]  mr_tkeep = '0;
  logic [63:0] eth_tdata;
  logic [7:0]  eth_tkeep;
  logic eth_tlast, eth_tvalid, eth_tuser, eth_tready = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  nettlp_eth_tx_sched dut (
    .clk(clk), .rst(rst), .tstamp_i(tstamp_i),
    .cpl_req(cpl_req), .cpl_len(cpl_len), .cpl_ack(cpl_ack), .cpl_tdata(cpl_tdata),
    .cpl_tkeep(cpl_tkeep), .cpl_tlast(cpl_tlast), .cpl_tvalid(cpl_tvalid), .cpl_tready(cpl_tready),
    .mr_req(mr_req), .mr_len(mr_len), .mr_ack(mr_ack), .mr_tdata(mr_tdata),
    .mr_tkeep(mr_tkeep), .mr_tlast(mr_tlast), .mr_tvalid(mr_tvalid), .mr_tready(mr_tready),
    .eth_tdata(eth_tdata), .eth_tkeep(eth_tkeep), .eth_tlast(eth_tlast), .eth_tvalid(eth_tvalid),
    .eth_tuser(eth_tuser), .eth_tready(eth_tready), .dbg_state(dbg_state)
  );

  typedef struct {
    logic mr; logic [10:0] len; logic [31:0] ts;
    logic [15:0] exp_tot; logic [15:0] exp_udp; logic [15:0] exp_port;
  } vec_t;
  vec_t vecs[5];

  int checks = 0, failures = 0, cyc = 0;
  logic [72:0] cpl_src_q[$], mr_src_q[$], exp_q[$];
  logic [15:0] rx_port_q[$], rx_seq_q[$];
  logic [7:0]  h[48], rx[48];
  logic [10:0] pend_len[2];
  logic [9:0]  m_seq[2];
  logic [15:0] cap_tot, cap_udp, cap_sport, cap_dport;
  logic [31:0] cap_ts;
  logic [72:0] prev_beat, cur_beat, exp_beat;
  bit m_busy, m_prio_mr, m_sel_mr, first_seen, prev_stall, stall_mode;
  bit cpl_pop, mr_pop, drop_cpl, drop_mr, e_cpl, e_mr, gmr;
  int ack_cyc, rx_beat;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [15:0] ones_sum(input int first, input int last, input bit use_rx);
    logic [31:0] s;
    s = 0;
    for (int i = first; i < last; i += 2) s += use_rx ? {rx[i], rx[i+1]} : {h[i], h[i+1]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  // Builds the expected frame for a grant in wire byte order and queues it.
  task automatic push_frame(input bit mr);
    logic [15:0] tot, udp, pt, ck;
    logic [63:0] d;
    tot = 16'd34 + {5'd0, pend_len[mr]};
    udp = 16'd14 + {5'd0, pend_len[mr]};
    pt  = mr ? 16'h4000 : 16'h3000;
    for (int i = 0; i < 6; i++) begin h[i] = T_DST_MAC[47-8*i -: 8]; h[6+i] = T_SRC_MAC[47-8*i -: 8]; end
    h[12] = 8'h08; h[13] = 8'h00; h[14] = 8'h45; h[15] = 8'h00;
    h[16] = tot[15:8]; h[17] = tot[7:0]; h[18] = 0; h[19] = 0; h[20] = 8'h40; h[21] = 0;
    h[22] = 8'd64; h[23] = 8'h11; h[24] = 0; h[25] = 0;
    for (int i = 0; i < 4; i++) begin h[26+i] = T_SRC_IP[31-8*i -: 8]; h[30+i] = T_DST_IP[31-8*i -: 8]; end
    h[34] = pt[15:8]; h[35] = pt[7:0]; h[36] = pt[15:8]; h[37] = pt[7:0];
    h[38] = udp[15:8]; h[39] = udp[7:0]; h[40] = 0; h[41] = 0;
    h[42] = {6'd0, m_seq[mr][9:8]}; h[43] = m_seq[mr][7:0];
    for (int i = 0; i < 4; i++) h[44+i] = tstamp_i[31-8*i -: 8];
    ck = ~ones_sum(14, 34, 1'b0);
    h[24] = ck[15:8]; h[25] = ck[7:0];
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = h[8*b+k];
      exp_q.push_back({1'b0, 8'hFF, d});
    end
    if (mr) foreach (mr_src_q[i]) exp_q.push_back(mr_src_q[i]);
    else    foreach (cpl_src_q[i]) exp_q.push_back(cpl_src_q[i]);
    m_seq[mr] = m_seq[mr] + 10'd1;
  endtask

  task automatic clear_model();
    cpl_src_q.delete(); mr_src_q.delete(); exp_q.delete();
    cpl_req = 0; mr_req = 0; cpl_tvalid = 0; mr_tvalid = 0;
    m_busy = 0; m_prio_mr = 0; m_seq[0] = 0; m_seq[1] = 0;
    cpl_pop = 0; mr_pop = 0; drop_cpl = 0; drop_mr = 0; prev_stall = 0; rx_beat = 0;
  endtask

  // Per-cycle driver and monitor: drive on the falling edge, sample 1 ns later.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (cpl_pop) void'(cpl_src_q.pop_front());
        if (mr_pop)  void'(mr_src_q.pop_front());
        if (drop_cpl) begin cpl_req = 0; drop_cpl = 0; end
        if (drop_mr)  begin mr_req = 0;  drop_mr = 0;  end
        cpl_tvalid = cpl_src_q.size() > 0;
        {cpl_tlast, cpl_tkeep, cpl_tdata} = cpl_tvalid ? cpl_src_q[0] : 73'd0;
        mr_tvalid = mr_src_q.size() > 0;
        {mr_tlast, mr_tkeep, mr_tdata} = mr_tvalid ? mr_src_q[0] : 73'd0;
        eth_tready = stall_mode ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
        #1;
        e_cpl = 0; e_mr = 0;
        if (!m_busy && (cpl_req || mr_req)) begin
          gmr = mr_req && (!cpl_req || m_prio_mr);
          e_mr = gmr; e_cpl = !gmr;
        end
        check("ack", {cpl_ack, mr_ack}, {e_cpl, e_mr});
        if (e_cpl || e_mr) begin
          push_frame(gmr);
          m_busy = 1; m_sel_mr = gmr; ack_cyc = cyc; first_seen = 0; rx_beat = 0;
          if (gmr) drop_mr = 1; else drop_cpl = 1;
        end
        cur_beat = {eth_tlast, eth_tkeep, eth_tdata};
        if (prev_stall) check("hold", {eth_tvalid, cur_beat}, {1'b1, prev_beat});
        if (eth_tvalid && !first_seen) begin
          check("latency", cyc - ack_cyc, 2);
          first_seen = 1;
        end
        if (eth_tvalid && eth_tready) begin
          if (exp_q.size() == 0) check("extra_beat", {eth_tuser, cur_beat}, 74'd0);
          else begin
            exp_beat = exp_q.pop_front();
            check("beat", {eth_tuser, cur_beat}, {1'b0, exp_beat});
            if (exp_beat[72]) begin m_busy = 0; m_prio_mr = !m_sel_mr; end
          end
          if (rx_beat < 6) for (int k = 0; k < 8; k++) rx[8*rx_beat+k] = eth_tdata[8*k +: 8];
          rx_beat++;
          if (rx_beat == 5) check("ip_csum_sum", ones_sum(14, 34, 1'b1), 16'hFFFF);
          if (rx_beat == 6) begin
            cap_tot = {rx[16], rx[17]}; cap_sport = {rx[34], rx[35]}; cap_dport = {rx[36], rx[37]};
            cap_udp = {rx[38], rx[39]}; cap_ts = {rx[44], rx[45], rx[46], rx[47]};
            rx_port_q.push_back(cap_sport); rx_seq_q.push_back({rx[42], rx[43]});
          end
        end
        prev_stall = eth_tvalid && !eth_tready;
        prev_beat  = cur_beat;
        cpl_pop = cpl_tvalid && cpl_tready;
        mr_pop  = mr_tvalid && mr_tready;
      end
    end
  end

  task automatic post_pkt(input bit mr, input logic [10:0] len);
    int n, nb;
    logic [63:0] d;
    n = 0;
    while (n < 3000 && (mr ? (mr_req || mr_src_q.size() != 0) : (cpl_req || cpl_src_q.size() != 0))) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 3000) check("post_timeout", n, 0);
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      if (mr) mr_src_q.push_back({b == nb-1, (b == nb-1 && len % 8 != 0) ? 8'h0F : 8'hFF, d});
      else    cpl_src_q.push_back({b == nb-1, (b == nb-1 && len % 8 != 0) ? 8'h0F : 8'hFF, d});
    end
    pend_len[mr] = len;
    if (mr) begin mr_len = len; mr_req = 1; end
    else begin cpl_len = len; cpl_req = 1; end
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (n < budget && (m_busy || cpl_req || mr_req || exp_q.size() != 0)) begin
      @(posedge clk); #2; n++;
    end
    if (n >= budget) check("quiet_timeout", n, 0);
  endtask

  task automatic hard_reset();
    rst = 1;
    clear_model();
    repeat (3) @(posedge clk);
    #2 rst = 0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 11'd16,   32'h1234_5678, 16'h0032, 16'h001E, 16'h3000};
    vecs[1] = '{1'b1, 11'd12,   32'hA5A5_0001, 16'h002E, 16'h001A, 16'h4000};
    vecs[2] = '{1'b0, 11'd1024, 32'h0000_0000, 16'h0422, 16'h040E, 16'h3000};
    vecs[3] = '{1'b1, 11'd100,  32'hFFFF_FFFF, 16'h0086, 16'h0072, 16'h4000};
    vecs[4] = '{1'b0, 11'd20,   32'h0BAD_CAFE, 16'h0036, 16'h0022, 16'h3000};
    stall_mode = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #2;
    check("reset_out", {cpl_ack, mr_ack, cpl_tready, mr_tready, eth_tvalid, eth_tdata, eth_tkeep,
                        eth_tlast, eth_tuser, dbg_state}, 0);
    rst = 0;
    @(posedge clk); #2;
    check("idle_out", {eth_tvalid, eth_tdata, eth_tkeep, eth_tlast, dbg_state}, 0);

    // Header field table; first entry is the single-CPL frame straight after reset.
    for (int v = 0; v < 5; v++) begin
      tstamp_i = vecs[v].ts;
      rx_seq_q.delete();
      post_pkt(vecs[v].mr, vecs[v].len);
      wait_quiet(400);
      check("tot_len", cap_tot, vecs[v].exp_tot);
      check("udp_len", cap_udp, vecs[v].exp_udp);
      check("ports", {cap_sport, cap_dport}, {vecs[v].exp_port, vecs[v].exp_port});
      check("tstamp", cap_ts, vecs[v].ts);
    end

    // Simultaneous requests: grants alternate CPL, MR, CPL, MR.
    hard_reset();
    rx_port_q.delete(); rx_seq_q.delete();
    for (int r = 0; r < 2; r++) begin
      post_pkt(1'b0, 11'd16);
      post_pkt(1'b1, 11'd24);
      wait_quiet(400);
    end
    check("rr_ports", {rx_port_q[0], rx_port_q[1], rx_port_q[2], rx_port_q[3]},
          {16'h3000, 16'h4000, 16'h3000, 16'h4000});
    check("rr_seq", {rx_seq_q[0], rx_seq_q[1], rx_seq_q[2], rx_seq_q[3]}, {16'd0, 16'd0, 16'd1, 16'd1});

    // Backpressure 1-0-0-1 through header and payload of both sources.
    stall_mode = 1;
    post_pkt(1'b0, 11'd36);
    post_pkt(1'b1, 11'd16);
    wait_quiet(800);
    stall_mode = 0;
    check("stall_drain", exp_q.size(), 0);

    // Sequence wrap after 1024 CPL frames; MR counter untouched.
    hard_reset();
    rx_seq_q.delete();
    for (int f = 0; f < 1025; f++) begin
      tstamp_i = $urandom;
      post_pkt(1'b0, 11'd12);
      wait_quiet(100);
    end
    check("seq_1024", rx_seq_q[1023], 16'h03FF);
    check("seq_wrap", rx_seq_q[1024], 16'h0000);
    post_pkt(1'b1, 11'd16);
    wait_quiet(100);
    check("mr_seq_untouched", rx_seq_q[1025], 16'h0000);

    // Reset while payload beat 1 is on the bus.
    hard_reset();
    post_pkt(1'b0, 11'd32);
    for (int n = 0; n < 100 && !(rx_beat == 7 && eth_tvalid); n++) begin @(posedge clk); #2; end
    check("reached_payload", rx_beat, 7);
    rst = 1;
    #1;
    check("rst_drops_valid", {eth_tvalid, cpl_tready, dbg_state}, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    rx_seq_q.delete(); rx_port_q.delete();
    post_pkt(1'b1, 11'd16);
    wait_quiet(100);
    check("post_rst_frame", {rx_port_q.size(), rx_port_q[0], rx_seq_q[0]}, {32'd1, 16'h4000, 16'h0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
